// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall sequencer.
// Used by pipe_hazard_ctrl and mem_wait_fsm.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

  localparam logic [3:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// Run / memory-wait / halt state machine with wait counter
// and sticky timeout flag.
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memstall,
  input  logic        wb_halt,
  output pipe_state_e state,
  output logic        err_timeout
);

  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;

  // Count of stalled cycles including the current one.
  assign wait_nxt = (state == MEMWAIT) ? wait_cnt + 8'd1 : 8'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      unique case (state)
        RUN, MEMWAIT: begin
          if (wb_halt) begin
            state    <= HALTED;
            wait_cnt <= '0;
          end else if (!memstall) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_nxt == MEM_TIMEOUT) begin
            state       <= HALTED;
            wait_cnt    <= '0;
            err_timeout <= 1'b1;
          end else begin
            state    <= MEMWAIT;
            wait_cnt <= wait_nxt;
          end
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Perf counters built only with PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idex_memread,
  input  logic [3:0]  idex_rd,
  input  logic [3:0]  ifid_rs,
  input  logic [3:0]  ifid_rt,
  input  logic        ifid_uses_rs,
  input  logic        ifid_uses_rt,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        wb_halt,
  output logic        pc_write,
  output logic        stall_ifid,
  output logic        flush_ifid,
  output logic        stall_idex,
  output logic        flush_idex,
  output logic        stall_exmem,
  output logic        flush_exmem,
  output logic        stall_memwb,
  output logic        flush_memwb,
  output logic        halted,
  output logic        err_timeout,
  output logic [15:0] cnt_loaduse,
  output logic [15:0] cnt_memwait,
  output logic [15:0] cnt_branch
);

  pipe_state_e state;
  stage_ctrl_t ifid, idex, exmem, memwb;
  logic memstall, loaduse, is_halt, live;
  logic sel_rst, sel_halt, sel_mem, sel_br, sel_lu;

  assign memstall = dmem_req & ~dmem_ready;
  assign loaduse  = idex_memread & (idex_rd != REG_ZERO)
                  & ((ifid_uses_rs & (ifid_rs == idex_rd))
                  |  (ifid_uses_rt & (ifid_rt == idex_rd)));

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .memstall   (memstall),
    .wb_halt    (wb_halt),
    .state      (state),
    .err_timeout(err_timeout)
  );

  // One-hot winning cause so the decoder below stays unique.
  assign is_halt  = (state == HALTED);
  assign live     = rst & ~is_halt;
  assign sel_rst  = ~rst;
  assign sel_halt = rst & is_halt;
  assign sel_mem  = live & memstall;
  assign sel_br   = live & ~memstall & ex_branch_taken;
  assign sel_lu   = live & ~memstall & ~ex_branch_taken & loaduse;

  always_comb begin
    ifid     = '0;
    idex     = '0;
    exmem    = '0;
    memwb    = '0;
    pc_write = 1'b1;
    unique case (1'b1)
      sel_rst: begin
        ifid.flush  = 1'b1;
        idex.flush  = 1'b1;
        exmem.flush = 1'b1;
        memwb.flush = 1'b1;
        pc_write    = 1'b0;
      end
      sel_halt: begin
        ifid.stall  = 1'b1;
        idex.stall  = 1'b1;
        exmem.stall = 1'b1;
        memwb.stall = 1'b1;
        pc_write    = 1'b0;
      end
      sel_mem: begin
        ifid.stall  = 1'b1;
        idex.stall  = 1'b1;
        exmem.stall = 1'b1;
        memwb.flush = 1'b1;
        pc_write    = 1'b0;
      end
      sel_br: begin
        ifid.flush = 1'b1;
        idex.flush = 1'b1;
      end
      sel_lu: begin
        ifid.stall = 1'b1;
        idex.flush = 1'b1;
        pc_write   = 1'b0;
      end
      default: ;
    endcase
  end

  assign stall_ifid  = ifid.stall;
  assign flush_ifid  = ifid.flush;
  assign stall_idex  = idex.stall;
  assign flush_idex  = idex.flush;
  assign stall_exmem = exmem.stall;
  assign flush_exmem = exmem.flush;
  assign stall_memwb = memwb.stall;
  assign flush_memwb = memwb.flush;
  assign halted      = sel_halt;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0] lu_q, mw_q, br_q;

  // Causes are already gated by live, so counters freeze in HALTED.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lu_q <= '0;
      mw_q <= '0;
      br_q <= '0;
    end else begin
      if (sel_lu && lu_q != 16'hFFFF) lu_q <= lu_q + 16'd1;
      if (sel_mem && mw_q != 16'hFFFF) mw_q <= mw_q + 16'd1;
      if (sel_br && br_q != 16'hFFFF) br_q <= br_q + 16'd1;
    end
  end

  assign cnt_loaduse = lu_q;
  assign cnt_memwait = mw_q;
  assign cnt_branch  = br_q;
`else
  assign cnt_loaduse = '0;
  assign cnt_memwait = '0;
  assign cnt_branch  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int TO = 5;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc, s_ifid, f_ifid, s_idex, f_idex, s_exmem, f_exmem, s_memwb, f_memwb, halted}
  localparam logic [9:0] C_NORM = 10'b1000000000;
  localparam logic [9:0] C_LU   = 10'b0100100000;
  localparam logic [9:0] C_BR   = 10'b1010100000;
  localparam logic [9:0] C_MEM  = 10'b0101010010;
  localparam logic [9:0] C_HALT = 10'b0101010101;
  localparam logic [9:0] C_RST  = 10'b0010101010;

  logic clk = 1'b0;
  logic rst;
  logic idex_memread;
  logic [3:0] idex_rd, ifid_rs, ifid_rt;
  logic ifid_uses_rs, ifid_uses_rt;
  logic ex_branch_taken, dmem_req, dmem_ready, wb_halt;
  logic pc_write, halted, err_timeout;
  logic stall_ifid, flush_ifid, stall_idex, flush_idex;
  logic stall_exmem, flush_exmem, stall_memwb, flush_memwb;
  logic [15:0] cnt_loaduse, cnt_memwait, cnt_branch;
  logic [9:0] ctl;

  int tests = 0;
  int fails = 0;

  bit m_halt;
  bit m_err;
  int m_run;
  int m_lu, m_mw, m_br;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(8'(TO))
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .idex_memread   (idex_memread),
    .idex_rd        (idex_rd),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .ifid_uses_rs   (ifid_uses_rs),
    .ifid_uses_rt   (ifid_uses_rt),
    .ex_branch_taken(ex_branch_taken),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .wb_halt        (wb_halt),
    .pc_write       (pc_write),
    .stall_ifid     (stall_ifid),
    .flush_ifid     (flush_ifid),
    .stall_idex     (stall_idex),
    .flush_idex     (flush_idex),
    .stall_exmem    (stall_exmem),
    .flush_exmem    (flush_exmem),
    .stall_memwb    (stall_memwb),
    .flush_memwb    (flush_memwb),
    .halted         (halted),
    .err_timeout    (err_timeout),
    .cnt_loaduse    (cnt_loaduse),
    .cnt_memwait    (cnt_memwait),
    .cnt_branch     (cnt_branch)
  );

  assign ctl = {pc_write, stall_ifid, flush_ifid, stall_idex,
                flush_idex, stall_exmem, flush_exmem, stall_memwb,
                flush_memwb, halted};

  // Priority rules applied directly to the current inputs.
  function automatic logic [9:0] exp_ctl();
    bit ms, lu;
    ms = dmem_req && !dmem_ready;
    lu = idex_memread && idex_rd != 0
      && ((ifid_uses_rs && ifid_rs == idex_rd)
      ||  (ifid_uses_rt && ifid_rt == idex_rd));
    if (!rst) return C_RST;
    if (m_halt) return C_HALT;
    if (ms) return C_MEM;
    if (ex_branch_taken) return C_BR;
    if (lu) return C_LU;
    return C_NORM;
  endfunction

  function automatic int sat(int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_step();
    logic [9:0] c;
    bit ms;
    c  = exp_ctl();
    ms = dmem_req && !dmem_ready;
    if (!rst) begin
      m_halt = 0; m_err = 0; m_run = 0;
      m_lu = 0; m_mw = 0; m_br = 0;
    end else if (!m_halt) begin
      if (c == C_MEM) m_mw = sat(m_mw);
      if (c == C_BR) m_br = sat(m_br);
      if (c == C_LU) m_lu = sat(m_lu);
      m_run = ms ? m_run + 1 : 0;
      if (wb_halt) m_halt = 1;
      else if (ms && m_run == TO) begin
        m_halt = 1;
        m_err  = 1;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idex_memread = 0; idex_rd = 0; ifid_rs = 0; ifid_rt = 0;
    ifid_uses_rs = 0; ifid_uses_rt = 0; ex_branch_taken = 0;
    dmem_req = 0; dmem_ready = 0; wb_halt = 0;
  endtask

  task automatic apply_reset();
    idle();
    rst = 0;
    step();
    rst = 1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #1;
    tests++;
    if (ctl !== C_RST) begin
      fails++;
      $display("FAIL reset_ctl: got %b want %b", ctl, C_RST);
    end
    step();
    tests++;
    if ({err_timeout, cnt_loaduse, cnt_memwait, cnt_branch} !== 49'd0) begin
      fails++;
      $display("FAIL reset_state: err %b cnt %h %h %h want 0",
               err_timeout, cnt_loaduse, cnt_memwait, cnt_branch);
    end
    rst = 1;
    #1;
    tests++;
    if (ctl !== C_NORM) begin
      fails++;
      $display("FAIL reset_release: got %b want %b", ctl, C_NORM);
    end
  endtask

  task automatic test_loaduse();
    apply_reset();
    idex_memread = 1; idex_rd = 3; ifid_rs = 3; ifid_uses_rs = 1;
    #1;
    tests++;
    if (ctl !== C_LU) begin
      fails++;
      $display("FAIL loaduse_rs: got %b want %b", ctl, C_LU);
    end
    step();
    idle();
    #1;
    tests++;
    if (ctl !== C_NORM) begin
      fails++;
      $display("FAIL loaduse_bubble: got %b want %b", ctl, C_NORM);
    end
    idex_memread = 1; idex_rd = 0; ifid_rs = 0; ifid_uses_rs = 1;
    #1;
    tests++;
    if (ctl !== C_NORM) begin
      fails++;
      $display("FAIL loaduse_r0: got %b want %b", ctl, C_NORM);
    end
    idex_rd = 7; ifid_rs = 2; ifid_rt = 7; ifid_uses_rt = 1;
    #1;
    tests++;
    if (ctl !== C_LU) begin
      fails++;
      $display("FAIL loaduse_rt: got %b want %b", ctl, C_LU);
    end
    ifid_uses_rt = 0;
    #1;
    tests++;
    if (ctl !== C_NORM) begin
      fails++;
      $display("FAIL loaduse_unqual: got %b want %b", ctl, C_NORM);
    end
    step();
    idle();
  endtask

  task automatic test_branch();
    apply_reset();
    idex_memread = 1; idex_rd = 3; ifid_rs = 3; ifid_uses_rs = 1;
    ex_branch_taken = 1;
    #1;
    tests++;
    if (ctl !== C_BR) begin
      fails++;
      $display("FAIL branch_over_lu: got %b want %b", ctl, C_BR);
    end
    dmem_req = 1;
    #1;
    tests++;
    if (ctl !== C_MEM) begin
      fails++;
      $display("FAIL mem_over_branch: got %b want %b", ctl, C_MEM);
    end
    dmem_ready = 1;
    #1;
    tests++;
    if (ctl !== C_BR) begin
      fails++;
      $display("FAIL ready_first: got %b want %b", ctl, C_BR);
    end
    step();
    idle();
    tests++;
    if (cnt_branch !== (PERF ? 16'd1 : 16'd0)) begin
      fails++;
      $display("FAIL cnt_branch: got %0d want %0d", cnt_branch, PERF);
    end
  endtask

  task automatic test_memwait();
    apply_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (ctl !== C_MEM) begin
        fails++;
        $display("FAIL memwait_c%0d: got %b want %b", i, ctl, C_MEM);
      end
      step();
    end
    dmem_ready = 1;
    #1;
    tests++;
    if (ctl !== C_NORM) begin
      fails++;
      $display("FAIL memwait_done: got %b want %b", ctl, C_NORM);
    end
    step();
    dmem_req = 0; dmem_ready = 0;
    #1;
    tests++;
    if (cnt_memwait !== (PERF ? 16'd4 : 16'd0) || ctl !== C_NORM) begin
      fails++;
      $display("FAIL memwait_cnt: got %0d ctl %b want %0d ctl %b",
               cnt_memwait, ctl, PERF ? 4 : 0, C_NORM);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= TO; i++) begin
      step();
      tests++;
      if (i < TO && (halted !== 1'b0 || err_timeout !== 1'b0)) begin
        fails++;
        $display("FAIL timeout_early%0d: halted %b err %b want 0 0",
                 i, halted, err_timeout);
      end else if (i == TO && (ctl !== C_HALT || err_timeout !== 1'b1)) begin
        fails++;
        $display("FAIL timeout_halt: ctl %b err %b want %b 1",
                 ctl, err_timeout, C_HALT);
      end
    end
    dmem_ready = 1;
    step();
    step();
    tests++;
    if (ctl !== C_HALT || cnt_memwait !== (PERF ? 16'd5 : 16'd0)) begin
      fails++;
      $display("FAIL timeout_hold: ctl %b cnt %0d want %b %0d",
               ctl, cnt_memwait, C_HALT, PERF ? 5 : 0);
    end
    idle();
  endtask

  task automatic test_halt_reset();
    apply_reset();
    wb_halt = 1;
    #1;
    tests++;
    if (ctl !== C_NORM) begin
      fails++;
      $display("FAIL halt_same_cycle: got %b want %b", ctl, C_NORM);
    end
    step();
    wb_halt = 0;
    ex_branch_taken = 1;
    #1;
    tests++;
    if (ctl !== C_HALT || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL halt_state: ctl %b err %b want %b 0",
               ctl, err_timeout, C_HALT);
    end
    step();
    rst = 0;
    #1;
    tests++;
    if (ctl !== C_RST) begin
      fails++;
      $display("FAIL halt_rst_ctl: got %b want %b", ctl, C_RST);
    end
    step();
    rst = 1;
    idle();
    #1;
    tests++;
    if (ctl !== C_NORM || cnt_branch !== 16'd0 || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL halt_recover: ctl %b br %0d err %b want %b 0 0",
               ctl, cnt_branch, err_timeout, C_NORM);
    end
  endtask

  task automatic test_random();
    logic [9:0] e;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 99) != 0);
      wb_halt         = ($urandom_range(0, 199) == 0);
      idex_memread    = $urandom_range(0, 1) == 1;
      idex_rd         = 4'($urandom_range(0, 3));
      ifid_rs         = 4'($urandom_range(0, 3));
      ifid_rt         = 4'($urandom_range(0, 3));
      ifid_uses_rs    = $urandom_range(0, 1) == 1;
      ifid_uses_rt    = $urandom_range(0, 1) == 1;
      ex_branch_taken = $urandom_range(0, 3) == 0;
      dmem_req        = $urandom_range(0, 1) == 1;
      dmem_ready      = $urandom_range(0, 2) == 0;
      #1;
      e = exp_ctl();
      tests++;
      if (ctl !== e || err_timeout !== m_err
          || cnt_loaduse !== (PERF ? 16'(m_lu) : 16'd0)
          || cnt_memwait !== (PERF ? 16'(m_mw) : 16'd0)
          || cnt_branch !== (PERF ? 16'(m_br) : 16'd0)) begin
        fails++;
        $display("FAIL random_%0d: ctl %b err %b cnt %0d %0d %0d want %b %b %0d %0d %0d",
                 i, ctl, err_timeout, cnt_loaduse, cnt_memwait, cnt_branch,
                 e, m_err, PERF ? m_lu : 0, PERF ? m_mw : 0, PERF ? m_br : 0);
      end
      step();
    end
    rst = 1;
    idle();
  endtask

  task automatic test_saturation();
    apply_reset();
    idex_memread = 1; idex_rd = 5; ifid_rt = 5; ifid_uses_rt = 1;
    for (int i = 0; i < 32'h10005; i++) begin
      model_step();
      @(posedge clk);
    end
    #1;
    tests++;
    if (cnt_loaduse !== (PERF ? 16'hFFFF : 16'd0)
        || cnt_loaduse !== (PERF ? 16'(m_lu) : 16'd0)) begin
      fails++;
      $display("FAIL loaduse_sat: got %h want %h",
               cnt_loaduse, PERF ? 16'hFFFF : 16'd0);
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 0;
    m_halt = 0; m_err = 0; m_run = 0;
    m_lu = 0; m_mw = 0; m_br = 0;
    #2;
    test_reset();
    test_loaduse();
    test_branch();
    test_memwait();
    test_timeout();
    test_halt_reset();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Drives the `stall`/`flush` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB buffers and the PC write enable. It resolves load-use hazards, taken-branch squashes, multi-cycle data-memory waits and the halt condition. A small state machine tracks memory-wait and halt; all stage controls are combinational from state and inputs, so they act on the same clock edge.

## Interface
- `MEM_TIMEOUT`, default 255 — maximum consecutive cycles in `MEMWAIT` before a timeout error; 8-bit value.
- `clk` in 1 — clock; all state updates on the rising edge.
- `rst` in 1 — synchronous, active-low reset.
- `idex_memread` in 1 — the instruction in EX is a load.
- `idex_rd` in 4 — destination register of the instruction in EX.
- `ifid_rs`, `ifid_rt` in 4 each — source registers of the instruction in ID.
- `ifid_uses_rs`, `ifid_uses_rt` in 1 each — qualify the ID source fields.
- `ex_branch_taken` in 1 — a branch or jump resolved taken in EX.
- `dmem_req` in 1 — the instruction in MEM accesses data memory.
- `dmem_ready` in 1 — data memory has completed the access this cycle.
- `wb_halt` in 1 — a halt instruction is in WB.
- `pc_write` out 1 — PC update enable.
- `stall_ifid`, `flush_ifid`, `stall_idex`, `flush_idex`, `stall_exmem`, `flush_exmem`, `stall_memwb`, `flush_memwb` out 1 each — buffer controls; stall has priority inside each buffer.
- `halted` out 1 — the core is halted.
- `err_timeout` out 1 — sticky memory-timeout error.
- `cnt_loaduse`, `cnt_memwait`, `cnt_branch` out 16 each — performance counters (see Configuration).

## Operation
- States: `RUN`, `MEMWAIT`, `HALTED`. A wait counter (8 bit) is active only in `MEMWAIT`.
- `memstall = dmem_req & ~dmem_ready`.
  - Any state other than `HALTED`: assert `stall_ifid`, `stall_idex`, `stall_exmem` and `flush_memwb`; deassert `pc_write`.
  - `RUN` with `memstall` -> `MEMWAIT`, counter = 1.
  - `MEMWAIT` with `dmem_ready` -> `RUN`, counter = 0.
  - `MEMWAIT` otherwise: counter +1.
  - Counter == `MEM_TIMEOUT` with `memstall` still true -> `HALTED`, set `err_timeout`.
- Load-use hazard:
  - Condition: `idex_memread & idex_rd != 0 & ((ifid_uses_rs & ifid_rs == idex_rd) | (ifid_uses_rt & ifid_rt == idex_rd))`.
  - Response: `pc_write = 0`, `stall_ifid = 1`, `flush_idex = 1`.
- Taken branch: `flush_ifid = 1`, `flush_idex = 1`, `pc_write = 1`.
- Priority, highest first: `HALTED` > `memstall` > taken branch > load-use > normal.
  - While `memstall` is true, the branch stays held in EX and is re-evaluated after the wait.
  - A branch overriding load-use squashes the dependent instruction.
- `wb_halt` in `RUN` or `MEMWAIT` -> `HALTED`.
- `HALTED` outputs: all stalls = 1, all flushes = 0, `pc_write = 0`, `halted = 1`. Only reset leaves `HALTED`.
- Normal operation (no hazard): all stall/flush = 0, `pc_write = 1`.

## Timing
- Stage controls have zero latency (combinational). State, counter and `err_timeout` update at the next edge.
- Behaviour while `rst` is low, at the edge: state `RUN`, counters 0, `err_timeout` 0.
- Output forcing while `rst` is low (combinational): all flushes = 1, all stalls = 0, `pc_write = 0`, `halted = 0`.
- Reset in `MEMWAIT` or `HALTED` returns to `RUN` on the same edge. No pending wait is retained.
- `dmem_ready` in the first request cycle means no stall and no state change.
- A timeout halt occurs after exactly `MEM_TIMEOUT` stalled cycles.

## Configuration
- `PIPE_HAZARD_CTRL_PERF_EN` defined:
  - Three 16-bit saturating counters (hold at 0xFFFF).
  - `cnt_loaduse`: cycles with load-use stall as the winning cause.
  - `cnt_memwait`: cycles with `memstall` true.
  - `cnt_branch`: taken-branch flush cycles.
  - Counters clear on reset and freeze in `HALTED`.
- Undefined: ports remain present and are tied to 0; no counter flops.

## Structure
- Package `pipe_ctrl_pkg`: state enum (`RUN`/`MEMWAIT`/`HALTED`), a `stage_ctrl_t` struct (stall, flush) and a register-zero constant.
- Sub-module `mem_wait_fsm`: owns the state register, wait counter and `err_timeout`. The top level holds the hazard compare, the priority mux and the perf counters.

## Test plan
- `idex_memread=1`, `idex_rd=3`, `ifid_rs=3`, `ifid_uses_rs=1` -> `pc_write=0`, `stall_ifid=1`, `flush_idex=1` for 1 cycle; the same compare with `rd=0` -> no stall.
- `ex_branch_taken=1` together with load-use -> `flush_ifid=1`, `flush_idex=1`, `pc_write=1`, `stall_ifid=0`.
- `dmem_req=1`, `dmem_ready` low for 4 cycles -> 4 cycles of front stalls plus `flush_memwb`; `cnt_memwait=4` (PERF build); state returns to `RUN`.
- `MEM_TIMEOUT=5`, `dmem_ready` held low -> `halted=1` and `err_timeout=1` after the 5th stalled cycle; all stalls = 1.
- `wb_halt=1` -> `HALTED`; drive `rst` low for 1 cycle -> `RUN`, counters 0, normal outputs next cycle.
- Load-use stalls for 0x10005 cycles in the PERF build -> `cnt_loaduse` saturates at 0xFFFF.
